multi_channel_prescaled_counter: RTL and testbench

Parametrised bank of N_CH independent event counters. A shared enable and a channel select route one event per cycle to a single channel. Each channel has a runtime-programmable prescaler, a wrap/saturate mode, a sticky overflow flag and a per-channel clear. Used as the general event/statistics counter block wherever fixed two-channel counters were previously hand-written.

---
 rtl/multi_channel_prescaled_counter.sv | 98 +++++++++
 tb/tb_multi_channel_prescaled_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_prescaled_counter.sv
// Bank of N_CH independent prescaled event counters sharing one event strobe.
// Each channel has a programmable divider, a wrap/saturate mode, a sticky overflow flag and a clear.
module mcpc_channel #(
   parameter int CNT_W   = 64,
   parameter int PRE_W   = 8,
   parameter int DEF_DIV = 0,
   parameter int DEF_SAT = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             clr,
   input  logic             cfg_we,
   input  logic [PRE_W-1:0] cfg_div,
   input  logic             cfg_sat,
   input  logic             ev,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);
   logic [PRE_W-1:0] pre;
   logic [PRE_W-1:0] div;
   logic             sat;

   // Priority chain: clear beats config, config beats event; the loser is dropped entirely.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count <= '0;
         ovf   <= 1'b0;
         pre   <= '0;
         div   <= PRE_W'(DEF_DIV);
         sat   <= 1'(DEF_SAT);
      end else if (clr) begin
         count <= '0;
         ovf   <= 1'b0;
         pre   <= '0;
      end else if (cfg_we) begin
         div <= cfg_div;
         sat <= cfg_sat;
         pre <= '0;
      end else if (ev) begin
         if (pre == div) begin
            pre <= '0;
            if (count != {CNT_W{1'b1}}) begin
               count <= count + CNT_W'(1);
            end else begin
               ovf <= 1'b1;
               if (!sat) count <= '0;
            end
         end else begin
            pre <= pre + PRE_W'(1);
         end
      end
   end
endmodule

module multi_channel_prescaled_counter #(
   parameter int N_CH    = 4,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 64,
   parameter int PRE_W   = 8,
   parameter int DEF_DIV = 0,
   parameter int DEF_SAT = 0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  En,
   input  logic [SEL_W-1:0]      Sel,
   input  logic                  Cfg_We,
   input  logic [SEL_W-1:0]      Cfg_Ch,
   input  logic [PRE_W-1:0]      Cfg_Div,
   input  logic                  Cfg_Sat,
   input  logic [N_CH-1:0]       Clr,
   output logic [N_CH*CNT_W-1:0] Count,
   output logic [N_CH-1:0]       Ovf
);
   logic [N_CH-1:0][CNT_W-1:0] cnt;

   // Out-of-range Sel/Cfg_Ch match no channel, so they fall through with no effect.
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      mcpc_channel #(
         .CNT_W  (CNT_W),
         .PRE_W  (PRE_W),
         .DEF_DIV(DEF_DIV),
         .DEF_SAT(DEF_SAT)
      ) u_ch (
         .Clk    (Clk),
         .Reset  (Reset),
         .clr    (Clr[k]),
         .cfg_we (Cfg_We && (Cfg_Ch == SEL_W'(k))),
         .cfg_div(Cfg_Div),
         .cfg_sat(Cfg_Sat),
         .ev     (En && (Sel == SEL_W'(k))),
         .count  (cnt[k]),
         .ovf    (Ovf[k])
      );
   end

   assign Count = cnt;
endmodule

// File: tb/tb_multi_channel_prescaled_counter.sv
// Scoreboard bench: stimulus queues the expected post-edge channel state, a negedge monitor compares it.
// A 4x64 build covers the main behaviour; a 3x8 build covers wrap/saturate and out-of-range selects.
module tb_multi_channel_prescaled_counter;
   logic         Clk = 1'b0;
   logic         Reset, En, Cfg_We, Cfg_Sat;
   logic [1:0]   Sel, Cfg_Ch;
   logic [7:0]   Cfg_Div;
   logic [3:0]   Clr;
   logic [255:0] Count;
   logic [3:0]   Ovf;

   logic         rst_s, en_s, we_s, sat_s;
   logic [1:0]   sel_s, ch_s;
   logic [7:0]   div_s;
   logic [2:0]   clr_s;
   logic [23:0]  count_s;
   logic [2:0]   ovf_s;

   typedef struct {
      int          due;
      bit          sm;
      int          ch;
      logic [63:0] cnt;
      logic        ovf;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   multi_channel_prescaled_counter u_dut (
      .Clk(Clk), .Reset(Reset), .En(En), .Sel(Sel), .Cfg_We(Cfg_We), .Cfg_Ch(Cfg_Ch),
      .Cfg_Div(Cfg_Div), .Cfg_Sat(Cfg_Sat), .Clr(Clr), .Count(Count), .Ovf(Ovf)
   );

   multi_channel_prescaled_counter #(.N_CH(3), .SEL_W(2), .CNT_W(8)) u_small (
      .Clk(Clk), .Reset(rst_s), .En(en_s), .Sel(sel_s), .Cfg_We(we_s), .Cfg_Ch(ch_s),
      .Cfg_Div(div_s), .Cfg_Sat(sat_s), .Clr(clr_s), .Count(count_s), .Ovf(ovf_s)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Monitor: each entry names the cycle whose post-edge state it describes.
   always @(negedge Clk) begin
      exp_t        e;
      logic [63:0] ac;
      logic        ao;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         if (e.sm) begin
            ac = {56'd0, count_s[e.ch*8 +: 8]};
            ao = ovf_s[e.ch];
         end else begin
            ac = Count[e.ch*64 +: 64];
            ao = Ovf[e.ch];
         end
         checks++;
         if (ac !== e.cnt || ao !== e.ovf) begin
            failures++;
            $display("FAIL %s ch%0d: count=%0d ovf=%b, expected count=%0d ovf=%b",
                     e.name, e.ch, ac, ao, e.cnt, e.ovf);
         end
      end
   end

   task automatic exp_m(input string n, input int ch, input logic [63:0] c, input logic o);
      exp_t e;
      e.due = cyc + 1; e.sm = 1'b0; e.ch = ch; e.cnt = c; e.ovf = o; e.name = n;
      q.push_back(e);
   endtask

   task automatic exp_s(input string n, input int ch, input logic [63:0] c, input logic o);
      exp_t e;
      e.due = cyc + 1; e.sm = 1'b1; e.ch = ch; e.cnt = c; e.ovf = o; e.name = n;
      q.push_back(e);
   endtask

   task automatic idle_m();
      Reset = 1'b0; En = 1'b0; Sel = 2'd0; Cfg_We = 1'b0; Cfg_Ch = 2'd0;
      Cfg_Div = 8'd0; Cfg_Sat = 1'b0; Clr = 4'd0;
   endtask

   task automatic idle_s();
      rst_s = 1'b0; en_s = 1'b0; sel_s = 2'd0; we_s = 1'b0; ch_s = 2'd0;
      div_s = 8'd0; sat_s = 1'b0; clr_s = 3'd0;
   endtask

   task automatic tick();
      @(negedge Clk);
   endtask

   initial begin
      idle_m(); idle_s();
      Reset = 1'b1; rst_s = 1'b1;
      for (int k = 0; k < 4; k++) exp_m("reset", k, 64'd0, 1'b0);
      for (int k = 0; k < 3; k++) exp_s("reset_s", k, 64'd0, 1'b0);
      tick(); tick();
      idle_m(); idle_s();

      // div=0: every event steps, one cycle latency
      for (int i = 1; i <= 5; i++) begin
         En = 1'b1; Sel = 2'd0; exp_m("t1_ev", 0, 64'(i), 1'b0); tick();
      end
      idle_m();
      exp_m("t1_ch0", 0, 64'd5, 1'b0);
      for (int k = 1; k < 4; k++) exp_m("t1_others", k, 64'd0, 1'b0);
      tick();

      // div=3: step on every 4th event
      Cfg_We = 1'b1; Cfg_Ch = 2'd1; Cfg_Div = 8'd3; exp_m("t2_cfg", 1, 64'd0, 1'b0); tick();
      idle_m();
      for (int i = 1; i <= 8; i++) begin
         En = 1'b1; Sel = 2'd1; exp_m("t2_ev", 1, 64'(i / 4), 1'b0); tick();
      end
      idle_m();

      // clear beats a same-cycle event
      for (int i = 6; i <= 7; i++) begin
         En = 1'b1; Sel = 2'd0; exp_m("t4_pre", 0, 64'(i), 1'b0); tick();
      end
      Clr = 4'b0001; En = 1'b1; Sel = 2'd0; exp_m("t4_clr_ev", 0, 64'd0, 1'b0); tick();
      idle_m();

      // independent actions on different channels
      Clr = 4'b0001; Cfg_We = 1'b1; Cfg_Ch = 2'd1; Cfg_Div = 8'd0; En = 1'b1; Sel = 2'd2;
      exp_m("t4_ind_c0", 0, 64'd0, 1'b0);
      exp_m("t4_ind_c1", 1, 64'd2, 1'b0);
      exp_m("t4_ind_c2", 2, 64'd1, 1'b0);
      tick(); idle_m();
      En = 1'b1; Sel = 2'd1; exp_m("t4_c1_newdiv", 1, 64'd3, 1'b0); tick(); idle_m();

      // config beats a same-cycle event; div=1 then needs two events
      Cfg_We = 1'b1; Cfg_Ch = 2'd3; Cfg_Div = 8'd1; En = 1'b1; Sel = 2'd3;
      exp_m("t4_cfg_ev", 3, 64'd0, 1'b0); tick(); idle_m();
      En = 1'b1; Sel = 2'd3; exp_m("t4_div1_a", 3, 64'd0, 1'b0); tick();
      exp_m("t4_div1_b", 3, 64'd1, 1'b0); tick(); idle_m();

      // clear beats a same-cycle config: div stays 1
      Clr = 4'b1000; Cfg_We = 1'b1; Cfg_Ch = 2'd3; Cfg_Div = 8'd2;
      exp_m("t4_clr_cfg", 3, 64'd0, 1'b0); tick(); idle_m();
      En = 1'b1; Sel = 2'd3; exp_m("t4_keepdiv_a", 3, 64'd0, 1'b0); tick();
      exp_m("t4_keepdiv_b", 3, 64'd1, 1'b0); tick(); idle_m();

      // 8-bit wrap on ch2
      for (int i = 1; i <= 256; i++) begin
         en_s = 1'b1; sel_s = 2'd2;
         if (i == 1 || i == 255) exp_s("t3_wrap_ev", 2, 64'(i), 1'b0);
         if (i == 256) exp_s("t3_wrap", 2, 64'd0, 1'b1);
         tick();
      end
      idle_s();
      we_s = 1'b1; ch_s = 2'd2; div_s = 8'd0; sat_s = 1'b1;
      exp_s("t3_cfg_keep", 2, 64'd0, 1'b1); tick(); idle_s();
      clr_s = 3'b100; exp_s("t3_clr", 2, 64'd0, 1'b0); tick(); idle_s();

      // 8-bit saturate on ch2
      for (int i = 1; i <= 300; i++) begin
         en_s = 1'b1; sel_s = 2'd2;
         if (i == 255) exp_s("t3_sat_max", 2, 64'd255, 1'b0);
         if (i == 256) exp_s("t3_sat_ovf", 2, 64'd255, 1'b1);
         if (i == 300) exp_s("t3_sat_hold", 2, 64'd255, 1'b1);
         tick();
      end
      idle_s();

      // out-of-range event and config select on the 3-channel build
      en_s = 1'b1; sel_s = 2'd3; we_s = 1'b1; ch_s = 2'd3; div_s = 8'd5; sat_s = 1'b0;
      exp_s("t5_c0", 0, 64'd0, 1'b0);
      exp_s("t5_c1", 1, 64'd0, 1'b0);
      exp_s("t5_c2", 2, 64'd255, 1'b1);
      tick(); idle_s();
      en_s = 1'b1; sel_s = 2'd0; exp_s("t5_c0_div", 0, 64'd1, 1'b0); tick();
      sel_s = 2'd1; exp_s("t5_c1_div", 1, 64'd1, 1'b0); tick();
      sel_s = 2'd2; exp_s("t5_c2_sat", 2, 64'd255, 1'b1); tick();
      idle_s();

      // reset restores DEF_DIV and clears pre
      Cfg_We = 1'b1; Cfg_Ch = 2'd0; Cfg_Div = 8'd3; tick(); idle_m();
      En = 1'b1; Sel = 2'd0; exp_m("t6_pre_a", 0, 64'd0, 1'b0); tick();
      exp_m("t6_pre_b", 0, 64'd0, 1'b0); tick(); idle_m();
      Reset = 1'b1;
      for (int k = 0; k < 4; k++) exp_m("t6_reset", k, 64'd0, 1'b0);
      tick(); idle_m();
      En = 1'b1; Sel = 2'd0; exp_m("t6_after_reset", 0, 64'd1, 1'b0); tick();
      idle_m(); tick();

      for (int w = 0; w < 10 && q.size() > 0; w++) tick();
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d expectations pending, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
